// File: rtl/imm_encode_loader_pkg.sv
// Shared types, opcode constants and the I/S-type instruction packer
// used by the immediate encode loader.
package imm_encode_pkg;

    typedef enum logic {
        IMM_SRC_I = 1'b0,
        IMM_SRC_S = 1'b1
    } imm_src_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam int IMM_MIN = -2048;
    localparam int IMM_MAX = 2047;

    function automatic logic [31:0] pack_instr(
        input imm_src_e    src,
        input logic [6:0]  opcode,
        input logic [2:0]  funct3,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        logic [31:0] word;
        if (src == IMM_SRC_S) begin
            word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        end else begin
            word = {imm[11:0], rs1, funct3, rd, opcode};
        end
        return word;
    endfunction

endpackage

// File: rtl/imm_encode_loader_if.sv
// Instruction-field input handshake and instruction-memory write bus
// of the immediate encode loader.
interface imm_encode_loader_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic         in_imm_src;
    logic [6:0]   in_opcode;
    logic [2:0]   in_funct3;
    logic [4:0]   in_rd;
    logic [4:0]   in_rs1;
    logic [4:0]   in_rs2;
    logic [N-1:0] in_imm;
    logic         imem_we;
    logic         imem_ready;
    logic [N-1:0] imem_addr;
    logic [N-1:0] imem_wdata;
    logic         err_range;
    logic [N-1:0] err_addr;
    logic [N-1:0] wr_count;

    modport master (
        output in_valid, in_imm_src, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        output imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, err_range, err_addr, wr_count
    );

    modport slave (
        input  in_valid, in_imm_src, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        input  imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, err_range, err_addr, wr_count
    );

endinterface

// File: rtl/imm_encode_loader_fifo.sv
// Small synchronous FIFO with flush; head word reads as zero while empty.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !flush && rst_n) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imm_encode_loader.sv
// Packs register fields and a signed immediate into I/S-type words, queues
// them and writes them to instruction memory at sequential word addresses.
module imm_encode_loader
    import imm_encode_pkg::*;
#(
    parameter int          N         = 32,
    parameter int          DEPTH     = 4,
    parameter logic [N-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    imm_encode_loader_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N-1:0]    addr_q;
    logic [N-1:0]    count_q;
    logic            err_q;
    logic [N-1:0]    err_addr_q;

    logic            full;
    logic            empty;
    logic [CW-1:0]   occupancy;
    logic [N-1:0]    head;
    logic [N-12:0]   imm_hi;
    logic            in_range;
    logic            accept;
    logic            push;
    logic            pop;
    logic [31:0]     packed_word;

    // Immediate fits 12 bits signed when every bit from 11 upward matches.
    assign imm_hi   = bus.in_imm[N-1:11];
    assign in_range = (&imm_hi) || !(|imm_hi);

    assign accept = bus.in_valid && !full;
    assign push   = accept && in_range && !load_start;
    assign pop    = !empty && bus.imem_ready && !load_start;

    assign packed_word = pack_instr(imm_src_e'(bus.in_imm_src), bus.in_opcode, bus.in_funct3,
                                    bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm[11:0]);

    sync_fifo #(
        .W     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (load_start),
        .push  (push),
        .wdata (N'(packed_word)),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || load_start) begin
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (pop) begin
                addr_q  <= addr_q + N'(4);
                count_q <= count_q + 1'b1;
            end
            // A dropped word would have landed after everything still queued.
            if (accept && !in_range && !err_q) begin
                err_q      <= 1'b1;
                err_addr_q <= addr_q + (N'(occupancy) << 2);
            end
        end
    end

    assign bus.in_ready   = !full;
    assign bus.imem_we    = !empty;
    assign bus.imem_wdata = head;
    assign bus.imem_addr  = addr_q;
    assign bus.wr_count   = count_q;
    assign bus.err_range  = err_q;
    assign bus.err_addr   = err_addr_q;

endmodule

// File: tb/tb_imm_encode_loader.sv
// Randomized and directed bench for imm_encode_loader against a queue-based
// reference model of the packing, range-drop and drain rules.
module tb_imm_encode_loader;
    import imm_encode_pkg::*;

    localparam int          N         = 32;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] BASE_ADDR = 32'h0;

    logic clk;
    logic rst_n;
    logic load_start;

    imm_encode_loader_if #(.N(N)) bus ();

    imm_encode_loader #(
        .N         (N),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing by field weights rather than concatenation.
    function automatic logic [31:0] ref_pack(input bit s, input int unsigned op, input int unsigned f3,
                                             input int unsigned rd, input int unsigned rs1,
                                             input int unsigned rs2, input logic [31:0] imm);
        int unsigned u;
        u = imm % 4096;
        if (!s) return u * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + op;
        return (u / 32) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
               + (u % 32) * (1 << 7) + op;
    endfunction

    function automatic bit imm_ok(input logic [31:0] imm);
        int v;
        v = $signed(imm);
        return (v >= IMM_MIN) && (v <= IMM_MAX);
    endfunction

    logic [31:0] mq[$];
    int unsigned m_addr;
    int unsigned m_cnt;
    int unsigned m_erraddr;
    bit          m_err;
    bit          live = 1'b0;

    always @(posedge clk) begin : model
        int unsigned sz;
        bit pop_ok;
        bit acc;
        sz = mq.size();
        if (!rst_n || load_start) begin
            mq.delete();
            m_addr    = BASE_ADDR;
            m_cnt     = 0;
            m_err     = 1'b0;
            m_erraddr = 0;
        end else begin
            pop_ok = (sz != 0) && bus.imem_ready;
            acc    = bus.in_valid && (sz < DEPTH);
            if (acc) begin
                if (imm_ok(bus.in_imm)) begin
                    mq.push_back(ref_pack(bus.in_imm_src, bus.in_opcode, bus.in_funct3, bus.in_rd,
                                          bus.in_rs1, bus.in_rs2, bus.in_imm));
                end else if (!m_err) begin
                    m_err     = 1'b1;
                    m_erraddr = m_addr + 4 * sz;
                end
            end
            if (pop_ok) begin
                void'(mq.pop_front());
                m_addr = m_addr + 4;
                m_cnt  = m_cnt + 1;
            end
        end
        live = 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("in_ready", bus.in_ready, mq.size() < DEPTH);
            chk("imem_we", bus.imem_we, mq.size() != 0);
            if (mq.size() != 0) chk("imem_wdata", bus.imem_wdata, mq[0]);
            chk("imem_addr", bus.imem_addr, m_addr);
            chk("wr_count", bus.wr_count, m_cnt);
            chk("err_range", bus.err_range, m_err);
            chk("err_addr", bus.err_addr, m_erraddr);
        end
    end

    task automatic drive(input bit v, input bit s, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        bus.in_valid   = v;
        bus.in_imm_src = s;
        bus.in_opcode  = op;
        bus.in_funct3  = f3;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_imm     = imm;
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_F800;
            1:       return 32'h0000_07FF;
            2:       return 32'h0000_0800;
            3:       return 32'hFFFF_F7FF;
            4:       return $urandom();
            default: return 32'($signed($urandom_range(0, 4095)) - 2048);
        endcase
    endfunction

    initial begin
        rst_n          = 1'b0;
        load_start     = 1'b0;
        bus.imem_ready = 1'b0;
        drive(0, 0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_we", bus.imem_we, 1'b0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_wr_count", bus.wr_count, 32'd0);
        chk("rst_err", bus.err_range, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // addi x5,x6,-1
        bus.imem_ready = 1'b1;
        drive(1, 0, OP_IMM, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("addi_we", bus.imem_we, 1'b1);
        chk("addi_wdata", bus.imem_wdata, 32'hFFF3_0293);
        chk("addi_addr", bus.imem_addr, 32'd0);
        @(negedge clk);
        chk("addi_next_addr", bus.imem_addr, 32'd4);
        chk("addi_wr_count", bus.wr_count, 32'd1);

        // sw x7,2044(x2)
        drive(1, 1, OP_STORE, 3'd2, 5'd0, 5'd2, 5'd7, 32'd2044);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("sw_wdata", bus.imem_wdata, 32'h7E71_2E23);
        @(negedge clk);

        // Out-of-range immediate behind two queued words
        load_start     = 1'b1;
        bus.imem_ready = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        drive(1, 0, OP_LOAD, 3'd2, 5'd1, 5'd2, 5'd0, 32'd8);
        @(negedge clk);
        drive(1, 1, OP_STORE, 3'd2, 5'd0, 5'd3, 5'd4, 32'hFFFF_FFF0);
        @(negedge clk);
        drive(1, 0, OP_IMM, 3'd0, 5'd9, 5'd9, 5'd0, 32'd2048);
        @(negedge clk);
        chk("range_err", bus.err_range, 1'b1);
        chk("range_err_addr", bus.err_addr, 32'd8);
        drive(1, 0, OP_IMM, 3'd0, 5'd10, 5'd10, 5'd0, 32'd3);
        @(negedge clk);

        // load_start with 3 queued and a word offered
        drive(1, 0, OP_IMM, 3'd0, 5'd11, 5'd11, 5'd0, 32'd4);
        load_start = 1'b1;
        @(negedge clk);
        load_start   = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_we", bus.imem_we, 1'b0);
        chk("flush_addr", bus.imem_addr, BASE_ADDR);
        chk("flush_err", bus.err_range, 1'b0);

        // Fill to full with imem stalled, then drain
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, OP_IMM, 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
            @(negedge clk);
        end
        chk("full_in_ready", bus.in_ready, 1'b0);
        drive(1, 0, OP_IMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        bus.imem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("fifth_addr", bus.imem_addr, 32'd16);
        chk("fifth_we", bus.imem_we, 1'b1);
        chk("fifth_wdata", bus.imem_wdata, 32'h0050_0093);
        @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  7'($urandom()), 3'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                  rand_imm());
            bus.imem_ready = $urandom_range(0, 2) != 0;
            load_start     = $urandom_range(0, 99) == 0;
            rst_n          = $urandom_range(0, 299) != 0;
            @(negedge clk);
        end
        drive(0, 0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        load_start     = 1'b0;
        rst_n          = 1'b1;
        bus.imem_ready = 1'b1;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
